// File: rtl/fft_peak_pkg.sv
// fft_peak_pkg: types and helpers shared by the FFT peak finder slice.
//   state_e    framing FSM state (StIdle, StInFrame)
//   pwr_width  width of an unsigned Re^2+Im^2 value for a given sample width
package fft_peak_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StInFrame
    } state_e;

    // The sum of two squares of DW-bit signed values peaks at 2^(2*DW-1), so 2*DW bits suffice.
    function automatic int unsigned pwr_width(input int unsigned data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/fft_peak_finder_if.sv
// fft_peak_finder_if: FFT source stream in, per-frame peak report out.
//   sink_sop/eop/valid, sink_Re/Im        frequency-domain beats from the FFT core
//   peak_valid/bin/pwr/Re/Im              strongest-bin report, one pulse per good frame
//   error                                 framing-violation pulse
// Modports: master = FFT source side (drives sink_*), slave = peak finder (drives peak_*/error).
interface fft_peak_finder_if #(
    parameter int unsigned POW        = 12,
    parameter int unsigned DATA_WIDTH = 20
);
    import fft_peak_pkg::*;

    localparam int unsigned PwrWidth = pwr_width(DATA_WIDTH);

    logic                         sink_sop;
    logic                         sink_eop;
    logic                         sink_valid;
    logic signed [DATA_WIDTH-1:0] sink_Re;
    logic signed [DATA_WIDTH-1:0] sink_Im;

    logic                         peak_valid;
    logic [POW-1:0]               peak_bin;
    logic [PwrWidth-1:0]          peak_pwr;
    logic signed [DATA_WIDTH-1:0] peak_Re;
    logic signed [DATA_WIDTH-1:0] peak_Im;
    logic                         error;

    modport master (
        output sink_sop, sink_eop, sink_valid, sink_Re, sink_Im,
        input  peak_valid, peak_bin, peak_pwr, peak_Re, peak_Im, error
    );

    modport slave (
        input  sink_sop, sink_eop, sink_valid, sink_Re, sink_Im,
        output peak_valid, peak_bin, peak_pwr, peak_Re, peak_Im, error
    );

endinterface

// File: rtl/fft_cplx_pwr.sv
// fft_cplx_pwr: two-stage Re^2+Im^2 pipeline with bin/sample/flag sideband.
//   clk, aclr_n                      clock, asynchronous active-low reset
//   valid_i, first_i, last_i         beat qualifier, first bin of frame, good end of frame
//   bin_i, re_i, im_i                bin index and complex sample
//   valid_o .. im_o                  same sideband delayed by two cycles
//   pwr_o                            unsigned Re^2+Im^2 aligned with the sideband
module fft_cplx_pwr
    import fft_peak_pkg::*;
#(
    parameter int unsigned POW        = 12,
    parameter int unsigned DATA_WIDTH = 20,
    localparam int unsigned PwrWidth  = pwr_width(DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         aclr_n,
    input  logic                         valid_i,
    input  logic                         first_i,
    input  logic                         last_i,
    input  logic [POW-1:0]               bin_i,
    input  logic signed [DATA_WIDTH-1:0] re_i,
    input  logic signed [DATA_WIDTH-1:0] im_i,
    output logic                         valid_o,
    output logic                         first_o,
    output logic                         last_o,
    output logic [POW-1:0]               bin_o,
    output logic signed [DATA_WIDTH-1:0] re_o,
    output logic signed [DATA_WIDTH-1:0] im_o,
    output logic [PwrWidth-1:0]          pwr_o
);
    localparam int unsigned ProdWidth = 2 * DATA_WIDTH;

    logic signed [ProdWidth-1:0]  re_ext, im_ext, re_sq_d, im_sq_d;
    logic signed [ProdWidth-1:0]  s1_re_sq_q, s1_im_sq_q;
    logic                         s1_valid_q, s1_first_q, s1_last_q;
    logic [POW-1:0]               s1_bin_q;
    logic signed [DATA_WIDTH-1:0] s1_re_q, s1_im_q;
    logic                         s2_valid_q, s2_first_q, s2_last_q;
    logic [POW-1:0]               s2_bin_q;
    logic signed [DATA_WIDTH-1:0] s2_re_q, s2_im_q;
    logic [PwrWidth-1:0]          s2_pwr_q;

    always_comb begin
        re_ext  = ProdWidth'(re_i);
        im_ext  = ProdWidth'(im_i);
        re_sq_d = re_ext * re_ext;
        im_sq_d = im_ext * im_ext;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bin_q   <= '0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_re_sq_q <= '0;
            s1_im_sq_q <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_bin_q   <= '0;
            s2_re_q    <= '0;
            s2_im_q    <= '0;
            s2_pwr_q   <= '0;
        end else begin
            s1_valid_q <= valid_i;
            s1_first_q <= first_i;
            s1_last_q  <= last_i;
            s1_bin_q   <= bin_i;
            s1_re_q    <= re_i;
            s1_im_q    <= im_i;
            s1_re_sq_q <= re_sq_d;
            s1_im_sq_q <= im_sq_d;
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_bin_q   <= s1_bin_q;
            s2_re_q    <= s1_re_q;
            s2_im_q    <= s1_im_q;
            // Squares are non-negative, so the unsigned sum cannot wrap.
            s2_pwr_q   <= PwrWidth'($unsigned(s1_re_sq_q)) + PwrWidth'($unsigned(s1_im_sq_q));
        end
    end

    assign valid_o = s2_valid_q;
    assign first_o = s2_first_q;
    assign last_o  = s2_last_q;
    assign bin_o   = s2_bin_q;
    assign re_o    = s2_re_q;
    assign im_o    = s2_im_q;
    assign pwr_o   = s2_pwr_q;

endmodule

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: tracks the strongest bin of each FFT frame and checks frame framing.
//   clk      clock, rising edge
//   aclr_n   asynchronous active-low reset; discards any partial frame
//   bus      fft_peak_finder_if.slave: sink_* stream in, peak_* report and error pulse out
// Build option: define FFT_PEAK_HALF_SPECTRUM_EN to restrict the max search to bins 0..N/2-1.
module fft_peak_finder
    import fft_peak_pkg::*;
#(
    parameter int unsigned POW        = 12,
    parameter int unsigned DATA_WIDTH = 20
) (
    input logic              clk,
    input logic              aclr_n,
    fft_peak_finder_if.slave bus
);
    localparam int unsigned    PwrWidth = pwr_width(DATA_WIDTH);
    localparam logic [POW-1:0] LastBin  = {POW{1'b1}};

    state_e         state_q;
    logic [POW-1:0] bin_q;
    logic           error_q;

    logic           beat_acc, beat_err, beat_last, beat_first, at_last;
    logic [POW-1:0] beat_bin;

    // A sop always restarts the count, whether or not a frame was open.
    always_comb begin
        beat_bin   = bus.sink_sop ? '0 : bin_q;
        beat_first = (beat_bin == '0);
        at_last    = (beat_bin == LastBin);
        beat_acc   = bus.sink_valid && (bus.sink_sop || state_q == StInFrame);
        // eop must coincide exactly with the last bin; either mismatch abandons the frame.
        beat_err   = bus.sink_valid && ((state_q == StIdle && !bus.sink_sop)
                                     || (state_q == StInFrame && bus.sink_sop)
                                     || (bus.sink_eop != at_last));
        beat_last  = beat_acc && bus.sink_eop && !beat_err;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= beat_err;
            if (beat_acc) begin
                if (bus.sink_eop || at_last) begin
                    state_q <= StIdle;
                    bin_q   <= '0;
                end else begin
                    state_q <= StInFrame;
                    bin_q   <= beat_bin + POW'(1);
                end
            end
        end
    end

    logic                         p_valid, p_first, p_last;
    logic [POW-1:0]               p_bin;
    logic signed [DATA_WIDTH-1:0] p_re, p_im;
    logic [PwrWidth-1:0]          p_pwr;

    fft_cplx_pwr #(
        .POW        (POW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pwr (
        .clk     (clk),
        .aclr_n  (aclr_n),
        .valid_i (beat_acc),
        .first_i (beat_first),
        .last_i  (beat_last),
        .bin_i   (beat_bin),
        .re_i    (bus.sink_Re),
        .im_i    (bus.sink_Im),
        .valid_o (p_valid),
        .first_o (p_first),
        .last_o  (p_last),
        .bin_o   (p_bin),
        .re_o    (p_re),
        .im_o    (p_im),
        .pwr_o   (p_pwr)
    );

    logic [POW-1:0]               max_bin_q, peak_bin_q;
    logic [PwrWidth-1:0]          max_pwr_q, peak_pwr_q;
    logic signed [DATA_WIDTH-1:0] max_re_q, max_im_q, peak_re_q, peak_im_q;
    logic                         done_q, peak_valid_q;
    logic                         in_range, take;

    always_comb begin
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
        in_range = !p_bin[POW-1];
`else
        in_range = 1'b1;
`endif
        // Strict compare keeps the lowest index on ties; bin 0 always reloads.
        take = p_valid && (p_first || (in_range && (p_pwr > max_pwr_q)));
    end

    // done_q gives one cycle for the final bin to settle in the tracker before it is published.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            max_bin_q    <= '0;
            max_pwr_q    <= '0;
            max_re_q     <= '0;
            max_im_q     <= '0;
            done_q       <= 1'b0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_pwr_q   <= '0;
            peak_re_q    <= '0;
            peak_im_q    <= '0;
        end else begin
            if (take) begin
                max_bin_q <= p_bin;
                max_pwr_q <= p_pwr;
                max_re_q  <= p_re;
                max_im_q  <= p_im;
            end
            done_q       <= p_valid && p_last;
            peak_valid_q <= done_q;
            if (done_q) begin
                peak_bin_q <= max_bin_q;
                peak_pwr_q <= max_pwr_q;
                peak_re_q  <= max_re_q;
                peak_im_q  <= max_im_q;
            end
        end
    end

    assign bus.peak_valid = peak_valid_q;
    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_pwr   = peak_pwr_q;
    assign bus.peak_Re    = peak_re_q;
    assign bus.peak_Im    = peak_im_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// tb_fft_peak_finder: directed + randomized frames against a per-frame peak model (N=16, DW=14).
module tb_fft_peak_finder;
    localparam int unsigned POW = 4;
    localparam int unsigned DW  = 14;
    localparam int          N   = 16;
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
    localparam int          Span = N / 2;
`else
    localparam int          Span = N;
`endif

    logic clk    = 1'b0;
    logic aclr_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_peak_finder_if #(.POW(POW), .DATA_WIDTH(DW)) bus ();

    fft_peak_finder #(.POW(POW), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    typedef struct {
        int                   cyc;
        logic [POW-1:0]       bin;
        logic [2*DW-1:0]      pwr;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } peak_t;

    peak_t pk_q[$];
    int    er_q[$];

    always @(negedge clk) begin
        if (bus.peak_valid === 1'b1)
            pk_q.push_back('{cyc, bus.peak_bin, bus.peak_pwr, bus.peak_Re, bus.peak_Im});
        if (bus.error === 1'b1) er_q.push_back(cyc);
    end

    logic signed [DW-1:0] fr_re [N];
    logic signed [DW-1:0] fr_im [N];
    int checks = 0;
    int errors = 0;
    int beat_cyc, first_cyc;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic beat(input bit sop, input bit eop, input logic signed [DW-1:0] re,
                        input logic signed [DW-1:0] im);
        bus.sink_valid = 1'b1;
        bus.sink_sop   = sop;
        bus.sink_eop   = eop;
        bus.sink_Re    = re;
        bus.sink_Im    = im;
        @(posedge clk);
        #1;
        beat_cyc       = cyc;
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int from, input int to, input bit do_sop, input bit do_eop,
                        input int max_gap);
        for (int i = from; i <= to; i++) begin
            if (i != from && max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
            beat(do_sop && i == from, do_eop && i == to, fr_re[i], fr_im[i]);
            if (i == from) first_cyc = beat_cyc;
        end
    endtask

    task automatic fill(input int lim);
        int v;
        for (int i = 0; i < N; i++) begin
            v = int'($urandom_range(2 * lim, 0)) - lim;
            fr_re[i] = DW'(v);
            v = int'($urandom_range(2 * lim, 0)) - lim;
            fr_im[i] = DW'(v);
        end
    endtask

    // Model: scan the compared bins, keep the first strictly largest power.
    task automatic ref_peak(output int bin, output longint pwr, output int re, output int im);
        longint best;
        longint p;
        best = -1;
        bin = 0; re = 0; im = 0;
        for (int i = 0; i < Span; i++) begin
            p = longint'(fr_re[i]) * longint'(fr_re[i]) + longint'(fr_im[i]) * longint'(fr_im[i]);
            if (p > best) begin
                best = p; bin = i; re = int'(fr_re[i]); im = int'(fr_im[i]);
            end
        end
        pwr = best;
    endtask

    task automatic exp_peak(input string tag, input int b, input longint p, input int r,
                            input int i, input int eop_cyc);
        peak_t pk;
        chk({tag, ".present"}, pk_q.size() > 0, 1);
        if (pk_q.size() > 0) begin
            pk = pk_q.pop_front();
            chk({tag, ".bin"}, pk.bin, b);
            chk({tag, ".pwr"}, pk.pwr, p);
            chk({tag, ".re"}, pk.re, r);
            chk({tag, ".im"}, pk.im, i);
            chk({tag, ".latency"}, pk.cyc - eop_cyc, 3);
        end
    endtask

    task automatic check_frame(input string tag, input int eop_cyc);
        int b, r, i;
        longint p;
        ref_peak(b, p, r, i);
        chk({tag, ".npeaks"}, pk_q.size(), 1);
        exp_peak(tag, b, p, r, i, eop_cyc);
        chk({tag, ".noerr"}, er_q.size(), 0);
        pk_q.delete(); er_q.delete();
    endtask

    task automatic check_err(input string tag, input int want_cyc);
        chk({tag, ".nerr"}, er_q.size(), 1);
        if (er_q.size() > 0) chk({tag, ".errcyc"}, er_q.pop_front(), want_cyc);
        chk({tag, ".nopeak"}, pk_q.size(), 0);
        pk_q.delete(); er_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".peak_valid"}, bus.peak_valid, 0);
        chk({tag, ".peak_bin"}, bus.peak_bin, 0);
        chk({tag, ".peak_pwr"}, bus.peak_pwr, 0);
        chk({tag, ".peak_Re"}, bus.peak_Re, 0);
        chk({tag, ".peak_Im"}, bus.peak_Im, 0);
        chk({tag, ".error"}, bus.error, 0);
    endtask

    int a_b, a_r, a_i, a_eop, err_at;
    longint a_p;

    initial begin
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        bus.sink_Re    = '0;
        bus.sink_Im    = '0;

        // Reset state
        idle(3);
        check_zero("reset");
        aclr_n = 1'b1;
        idle(2);

        // 1: single strong bin, contiguous frame
        for (int i = 0; i < N; i++) begin fr_re[i] = 10; fr_im[i] = 10; end
        fr_re[5] = 300; fr_im[5] = -400;
        send(0, N - 1, 1, 1, 0);
        idle(6);
        check_frame("t1", beat_cyc);

        // 2: tie between bins 3 and 9, random gaps
        for (int i = 0; i < N; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
        fr_re[3] = 100; fr_re[9] = 100;
        send(0, N - 1, 1, 1, 3);
        idle(6);
        check_frame("t2", beat_cyc);

        // Beat outside any frame is dropped and flagged
        beat(1'b0, 1'b0, 14'sd5, 14'sd5);
        err_at = beat_cyc;
        idle(6);
        check_err("stray", err_at);

        // 3a: early eop at bin 10, then a good random frame
        fill(8191);
        send(0, 10, 1, 1, 0);
        err_at = beat_cyc;
        idle(6);
        check_err("t3a", err_at);
        fill(8191);
        send(0, N - 1, 1, 1, 2);
        idle(6);
        check_frame("t3a.good", beat_cyc);

        // 3b: sop at bin 7 restarts; stale big values must not leak into the new frame
        for (int i = 0; i < N; i++) begin fr_re[i] = 4000; fr_im[i] = 4000; end
        send(0, 6, 1, 0, 0);
        fill(500);
        send(0, N - 1, 1, 1, 1);
        a_eop  = beat_cyc;
        err_at = first_cyc;
        idle(6);
        chk("t3b.nerr", er_q.size(), 1);
        if (er_q.size() > 0) chk("t3b.errcyc", er_q.pop_front(), err_at);
        check_frame("t3b", a_eop);

        // Missing eop: bin N-1 reached without eop
        fill(8191);
        send(0, N - 1, 1, 0, 0);
        err_at = beat_cyc;
        idle(6);
        check_err("noeop", err_at);

        // 4: back-to-back frames at the extremes of the input range
        fill(100);
        fr_re[0] = -8192; fr_im[0] = -8192;
        send(0, N - 1, 1, 1, 0);
        a_eop = beat_cyc;
        ref_peak(a_b, a_p, a_r, a_i);
        fill(100);
        fr_re[N - 1] = 8191; fr_im[N - 1] = 0;
        send(0, N - 1, 1, 1, 0);
        idle(6);
        chk("t4.npeaks", pk_q.size(), 2);
        exp_peak("t4.a", a_b, a_p, a_r, a_i, a_eop);
        check_frame("t4.b", beat_cyc);

        // 5: reset mid-frame at bin 8
        fill(8191);
        send(0, 8, 1, 0, 0);
        aclr_n = 1'b0;
        #1;
        check_zero("t5.rst");
        @(posedge clk);
        #1;
        aclr_n = 1'b1;
        idle(6);
        chk("t5.nopeak", pk_q.size(), 0);
        chk("t5.noerr", er_q.size(), 0);
        pk_q.delete(); er_q.delete();
        fill(8191);
        send(0, N - 1, 1, 1, 2);
        idle(6);
        check_frame("t5.good", beat_cyc);

        // 6: strongest bin in the upper half vs weaker bin in the lower half
        for (int i = 0; i < N; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
        fr_re[12] = 1000; fr_re[2] = 50;
        send(0, N - 1, 1, 1, 0);
        idle(6);
        check_frame("t6", beat_cyc);

        // A few random frames with gaps
        for (int k = 0; k < 6; k++) begin
            fill(8191);
            send(0, N - 1, 1, 1, 2);
            idle(6);
            check_frame("rand", beat_cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
